top_alu_8b: RTL and testbench



---
 rtl/top_alu_8b.sv | 135 +++++++++++++
 tb/tb_top_alu_8b.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/top_alu_8b.sv
// top_alu_8b: registered 4-bit-operand ALU with an 8-bit result and status flags.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request strobe; A, B, opcode sampled while high
//   A, B       4-bit unsigned operands
//   opcode     operation select (ADD SUB MUL DIV AND OR XOR SHL)
//   OUT        registered 8-bit result
//   out_valid  one-cycle pulse per new result
//   zero       OUT == 8'h00
//   carry      ADD carry-out / SUB borrow, else 0
//   dz_err     divide-by-zero on DIV, else 0
//
// Build option
//   ALU_INPUT_REG_EN  adds an input register stage (latency 2 instead of 1).
module top_alu_8b (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic [2:0] opcode,
   output logic [7:0] OUT,
   output logic       out_valid,
   output logic       zero,
   output logic       carry,
   output logic       dz_err
);

   typedef enum logic [2:0] {
      OP_ADD = 3'b000,
      OP_SUB = 3'b001,
      OP_MUL = 3'b010,
      OP_DIV = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_XOR = 3'b110,
      OP_SHL = 3'b111
   } op_t;

   logic       s_valid;
   logic [3:0] s_a;
   logic [3:0] s_b;
   logic [2:0] s_op;

`ifdef ALU_INPUT_REG_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_valid <= 1'b0;
         s_a     <= 4'h0;
         s_b     <= 4'h0;
         s_op    <= 3'b000;
      end else begin
         s_valid <= in_valid;
         s_a     <= A;
         s_b     <= B;
         s_op    <= opcode;
      end
   end
`else
   assign s_valid = in_valid;
   assign s_a     = A;
   assign s_b     = B;
   assign s_op    = opcode;
`endif

   logic [7:0] a8;
   logic [7:0] b8;
   logic [4:0] sum5;
   logic [3:0] quo;
   logic [3:0] rem;
   logic [7:0] res;
   logic       res_carry;
   logic       res_dz;

   assign a8   = {4'h0, s_a};
   assign b8   = {4'h0, s_b};
   assign sum5 = {1'b0, s_a} + {1'b0, s_b};

   always_comb begin
      res       = 8'h00;
      res_carry = 1'b0;
      res_dz    = 1'b0;
      quo       = 4'h0;
      rem       = 4'h0;
      case (op_t'(s_op))
         OP_ADD: begin
            res       = {3'b000, sum5};
            res_carry = sum5[4];
         end
         OP_SUB: begin
            res       = a8 - b8;
            res_carry = (s_a < s_b);
         end
         OP_MUL: res = a8 * b8;
         OP_DIV: begin
            // Divider is only evaluated for non-zero B so no X ever leaks out.
            if (s_b == 4'h0) begin
               res    = 8'hFF;
               res_dz = 1'b1;
            end else begin
               quo = s_a / s_b;
               rem = s_a % s_b;
               res = {rem, quo};
            end
         end
         OP_AND: res = {4'h0, s_a & s_b};
         OP_OR:  res = {4'h0, s_a | s_b};
         OP_XOR: res = {4'h0, s_a ^ s_b};
         OP_SHL: res = a8 << s_b[2:0];
         default: res = 8'h00;
      endcase
   end

   // Result and flags hold between requests; only out_valid follows every edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         OUT       <= 8'h00;
         out_valid <= 1'b0;
         zero      <= 1'b0;
         carry     <= 1'b0;
         dz_err    <= 1'b0;
      end else begin
         out_valid <= s_valid;
         if (s_valid) begin
            OUT    <= res;
            zero   <= (res == 8'h00);
            carry  <= res_carry;
            dz_err <= res_dz;
         end
      end
   end

endmodule

// File: tb/tb_top_alu_8b.sv
module tb_top_alu_8b;

`ifdef ALU_INPUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, DIV = 3'b011;
   localparam logic [2:0] AND_ = 3'b100, OR_ = 3'b101, XOR_ = 3'b110, SHL = 3'b111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [3:0] A = 4'h0;
   logic [3:0] B = 4'h0;
   logic [2:0] opcode = 3'b000;
   logic [7:0] OUT;
   logic       out_valid, zero, carry, dz_err;

   top_alu_8b dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
      .OUT(OUT), .out_valid(out_valid), .zero(zero), .carry(carry), .dz_err(dz_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       v;
      logic [7:0] o;
      logic       z;
      logic       c;
      logic       d;
   } exp_t;

   exp_t pipe [0:1];
   exp_t held;
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      held = '{v: 1'b0, o: 8'h00, z: 1'b0, c: 1'b0, d: 1'b0};
      pipe[0] = held;
      pipe[1] = held;
   endtask

   task automatic check_outputs(input string tag, input exp_t e);
      check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, e.v});
      check({tag, ".OUT"},       OUT,                e.o);
      check({tag, ".zero"},      {7'b0, zero},       {7'b0, e.z});
      check({tag, ".carry"},     {7'b0, carry},      {7'b0, e.c});
      check({tag, ".dz_err"},    {7'b0, dz_err},     {7'b0, e.d});
   endtask

   // At each falling edge: check the entry issued LAT cycles earlier, then
   // drive a new request. Invalid requests expect the last valid result held.
   task automatic step(input string tag, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic [2:0] op,
                       input logic [7:0] eo, input logic ez, input logic ec,
                       input logic ed);
      exp_t e;
      @(negedge clk);
      check_outputs(tag, pipe[LAT-1]);
      if (v) held = '{v: 1'b1, o: eo, z: ez, c: ec, d: ed};
      e   = held;
      e.v = v;
      pipe[1] = pipe[0];
      pipe[0] = e;
      in_valid = v;
      A = a;
      B = b;
      opcode = op;
   endtask

   task automatic idle(input string tag);
      step(tag, 1'b0, 4'h0, 4'h0, ADD, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      clear_model();
      repeat (2) @(negedge clk);
      rst = 1'b0;

      idle("rst0");
      // A=15, B=10 through every opcode back-to-back
      step("add", 1, 15, 10, ADD,  8'h19, 0, 1, 0);
      step("sub", 1, 15, 10, SUB,  8'h05, 0, 0, 0);
      step("mul", 1, 15, 10, MUL,  8'h96, 0, 0, 0);
      step("div", 1, 15, 10, DIV,  8'h51, 0, 0, 0);
      step("and", 1, 15, 10, AND_, 8'h0A, 0, 0, 0);
      step("or",  1, 15, 10, OR_,  8'h0F, 0, 0, 0);
      step("xor", 1, 15, 10, XOR_, 8'h05, 0, 0, 0);
      step("shl", 1, 15, 10, SHL,  8'h3C, 0, 0, 0);
      // boundary cases
      step("sub_borrow", 1, 5, 10, SUB,  8'hFB, 0, 1, 0);
      step("add_carry",  1, 15, 1, ADD,  8'h10, 0, 1, 0);
      step("and_zero",   1, 5, 10, AND_, 8'h00, 1, 0, 0);
      step("div_by0",    1, 9, 0,  DIV,  8'hFF, 0, 0, 1);
      step("div_9_4",    1, 9, 4,  DIV,  8'h12, 0, 0, 0);
      step("mul_max",    1, 15, 15, MUL, 8'hE1, 0, 0, 0);
      step("shl_b3",     1, 1, 15, SHL,  8'h80, 0, 0, 0);
      step("sub_eq",     1, 7, 7,  SUB,  8'h00, 1, 0, 0);
      // valid pulses 1,0,1 with a hold gap
      step("gap_a",      1, 5, 3,  ADD,  8'h08, 0, 0, 0);
      idle("gap_hold");
      step("gap_b",      1, 2, 3,  MUL,  8'h06, 0, 0, 0);
      idle("drain0");
      idle("drain1");
      idle("drain2");

      // Asynchronous reset while out_valid is high, with a request in flight
      step("pre_rst0", 1, 3, 4, ADD, 8'h07, 0, 0, 0);
      step("pre_rst1", 1, 9, 0, DIV, 8'hFF, 0, 0, 1);
      @(posedge clk);
      #2;
      check("rst_pre.out_valid", {7'b0, out_valid}, 8'h01);
      rst = 1'b1;
      #1;
      check_outputs("rst_async", '{v: 1'b0, o: 8'h00, z: 1'b0, c: 1'b0, d: 1'b0});
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      clear_model();
      idle("post_rst0");
      idle("post_rst1");
      step("post_rst_req", 1, 15, 15, MUL, 8'hE1, 0, 0, 0);
      idle("post_rst2");
      idle("post_rst3");
      idle("post_rst4");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
